cin_convert_ctrl: RTL and testbench
===================================

// Module: cin_convert_ctrl
// PURPOSE
// - Per-layer sequencer for the input-channel conversion stage.
// - Latches the layer config on Start and drives the registered mode select EN_Cin_Select_REG.
// - Gates upstream/downstream valid/ready so exactly Cfg_In_Num beats enter and Cfg_Out_Num beats leave the stage.
// - Pulses Done when both counts are met; sits between the layer-config register bank and the Cin conversion datapath.
// PARAMETERS
// - CNT_WIDTH  20  width of beat counters and count config inputs
// PORTS
// clk              in   1          system clock, all logic rising-edge
// rst_n            in   1          asynchronous active-low reset
// Start            in   1          1-cycle layer start pulse; ignored unless state==IDLE
// Cfg_Cin_Select   in   1          conversion mode for this layer (1=convert, 0=bypass)
// Cfg_In_Num       in   CNT_WIDTH  input beats to accept this layer
// Cfg_Out_Num      in   CNT_WIDTH  output beats to deliver this layer
// S_Valid          in   1          upstream valid
// S_Ready          out  1          upstream ready
// Conv_S_Valid     out  1          valid to conversion stage
// Conv_S_Ready     in   1          ready from conversion stage
// Conv_M_Valid     in   1          valid from conversion stage
// Conv_M_Ready     out  1          ready to conversion stage
// M_Valid          out  1          downstream valid
// M_Ready          in   1          downstream ready
// EN_Cin_Select_REG out 1          registered mode select to conversion stage
// Busy             out  1          1 in LOAD/RUN/DRAIN
// Done             out  1          1-cycle pulse at layer completion
// Err_Zero         out  1          sticky: last Start had Cfg_In_Num==0 or Cfg_Out_Num==0
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, counters=0, EN_Cin_Select_REG=0, Done=0, Err_Zero=0, Busy=0, all gated valid/ready=0.
// - States: IDLE, LOAD, RUN, DRAIN, DONE.
// - IDLE: on Start, latch Cfg_*; clear Err_Zero. Any count==0: set Err_Zero, go DONE. Else go LOAD.
// - LOAD (1 cycle): EN_Cin_Select_REG <= latched Cfg_Cin_Select; counters cleared; -> RUN.
//   - EN_Cin_Select_REG changes only here; it holds through DONE/IDLE until the next LOAD.
//   - No data moves in LOAD, so the datapath sees a stable mode before the first beat.
// - in_act = (state==RUN) && (in_cnt != In_Num).
//   - Conv_S_Valid = S_Valid & in_act; S_Ready = Conv_S_Ready & in_act (combinational).
// - out_act = (state==RUN || state==DRAIN) && (out_cnt != Out_Num).
//   - M_Valid = Conv_M_Valid & out_act; Conv_M_Ready = M_Ready & out_act (combinational).
// - Counters: in_cnt++ on S_Valid&S_Ready; out_cnt++ on M_Valid&M_Ready.
//   - Counters saturate at their target (gating guarantees no overshoot).
//   - Input and output handshakes in the same cycle both count.
// - RUN -> DRAIN when the input count completes: in_cnt==In_Num, or in_cnt==In_Num-1 with an input handshake this cycle.
// - DRAIN -> DONE when the output count completes by the same rule.
// - RUN -> DONE directly when both counts complete in the same cycle.
// - Output count completing before input count: stay in RUN with out_act=0 until inputs finish, then -> DONE.
// - DONE: Done=1 for exactly one cycle, Busy=0; -> IDLE. Start arriving in DONE is ignored.
// - Start while Busy: ignored, no config change.
// - Latency: Start at cycle T -> LOAD at T+1 -> first beat can pass at T+2.
// - Reset mid-layer: immediate abort to IDLE with all outputs at reset values; no Done pulse.
// TESTING
// - Bypass layer: Cfg_Cin_Select=0, In=Out=4, always valid/ready.
//   - EN=0; 4 beats each way; RUN at T+2; Done pulse at T+6.
// - Convert layer: Cfg_Cin_Select=1, In=8, Out=4; converter emits 1 out per 2 in.
//   - EN=1 from T+2; S_Ready drops after 8th input; DRAIN until 4th output; Done once.
// - Backpressure: M_Ready toggling 1010, S_Valid random, In=Out=16.
//   - Counts exact; no handshake after target; M_Valid=0 when out_cnt==16.
// - Zero config: Start with Cfg_In_Num=0 -> Err_Zero=1, Done pulse at T+1, EN unchanged, no beats pass.
// - Start abuse: Start during RUN with different Cfg -> ignored, EN and counts unchanged; new Start after Done is accepted.
// - Reset mid-RUN after 3 of 8 beats, then In=Out=2 -> outputs return to reset values asynchronously; new layer completes cleanly.

Source files
------------

// File: rtl/cin_convert_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cin_convert_ctrl_if
// Description : Stream handshake bundle around the Cin conversion stage.
//               Carries the upstream (S_*), conversion-stage side
//               (Conv_S_* / Conv_M_*) and downstream (M_*) valid/ready pairs.
//               slave  : the sequencer view (gates valid/ready).
//               master : the surrounding environment view (upstream source,
//                        conversion datapath and downstream sink).
// Revision    : 1.0  initial release
// ============================================================================
interface cin_convert_ctrl_if;

  // Upstream source -> stage
  logic S_Valid;
  logic S_Ready;

  // Stage -> conversion datapath input
  logic Conv_S_Valid;
  logic Conv_S_Ready;

  // Conversion datapath output -> stage
  logic Conv_M_Valid;
  logic Conv_M_Ready;

  // Stage -> downstream sink
  logic M_Valid;
  logic M_Ready;

  modport slave (
    input  S_Valid,
    output S_Ready,
    output Conv_S_Valid,
    input  Conv_S_Ready,
    input  Conv_M_Valid,
    output Conv_M_Ready,
    output M_Valid,
    input  M_Ready
  );

  modport master (
    output S_Valid,
    input  S_Ready,
    input  Conv_S_Valid,
    output Conv_S_Ready,
    output Conv_M_Valid,
    input  Conv_M_Ready,
    input  M_Valid,
    output M_Ready
  );

endinterface : cin_convert_ctrl_if
`default_nettype wire

// File: rtl/cin_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cin_convert_ctrl
// Description : Per-layer sequencer for the input-channel conversion stage.
//               Latches the layer configuration on Start, presents a stable
//               registered mode select to the conversion datapath, and gates
//               the stream handshakes so exactly Cfg_In_Num beats enter and
//               Cfg_Out_Num beats leave the stage. Pulses Done on completion.
//
// Ports       :
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   Start             in   1-cycle layer start pulse (honoured only in IDLE)
//   Cfg_Cin_Select    in   conversion mode for the layer (1=convert, 0=bypass)
//   Cfg_In_Num        in   input beats to accept this layer
//   Cfg_Out_Num       in   output beats to deliver this layer
//   bus               --   handshake bundle (slave modport)
//   EN_Cin_Select_REG out  registered mode select to the conversion stage
//   Busy              out  high in LOAD / RUN / DRAIN
//   Done              out  1-cycle completion pulse
//   Err_Zero          out  sticky: last accepted Start had a zero count
//
// Revision    : 1.0  initial release
// ============================================================================
module cin_convert_ctrl #(
  parameter int CNT_WIDTH = 20
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 Start,
  input  wire logic                 Cfg_Cin_Select,
  input  wire logic [CNT_WIDTH-1:0] Cfg_In_Num,
  input  wire logic [CNT_WIDTH-1:0] Cfg_Out_Num,
  cin_convert_ctrl_if.slave         bus,
  output      logic                 EN_Cin_Select_REG,
  output      logic                 Busy,
  output      logic                 Done,
  output      logic                 Err_Zero
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]           state_q;
  logic [2:0]           state_d;

  logic                 sel_q;       // latched Cfg_Cin_Select
  logic [CNT_WIDTH-1:0] in_num_q;    // latched Cfg_In_Num
  logic [CNT_WIDTH-1:0] out_num_q;   // latched Cfg_Out_Num

  logic [CNT_WIDTH-1:0] in_cnt_q;
  logic [CNT_WIDTH-1:0] in_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q;
  logic [CNT_WIDTH-1:0] out_cnt_d;

  logic                 en_q;        // mode select presented to datapath
  logic                 err_q;       // zero-count flag of the last Start

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic start_acc;    // Start honoured this cycle
  logic cfg_zero;     // requested layer has a zero beat count
  logic in_act;       // input side may still transfer
  logic out_act;      // output side may still transfer
  logic in_hs;        // upstream handshake this cycle
  logic out_hs;       // downstream handshake this cycle
  logic in_fin;       // input count complete by the end of this cycle
  logic out_fin;      // output count complete by the end of this cycle

  assign start_acc = Start && (state_q == ST_IDLE);
  assign cfg_zero  = (Cfg_In_Num == CNT_ZERO) || (Cfg_Out_Num == CNT_ZERO);

  // The activity windows close as soon as a counter reaches its target, so
  // the counters can never overshoot and no handshake leaks past the layer.
  assign in_act  = (state_q == ST_RUN) && (in_cnt_q != in_num_q);
  assign out_act = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                   (out_cnt_q != out_num_q);

  assign in_hs  = bus.S_Valid && bus.Conv_S_Ready && in_act;
  assign out_hs = bus.Conv_M_Valid && bus.M_Ready && out_act;

  // Completion looks one beat ahead so the FSM leaves RUN/DRAIN on the same
  // edge that records the final handshake.
  assign in_fin  = (in_cnt_q == in_num_q) ||
                   (in_hs && (in_cnt_q == (in_num_q - CNT_ONE)));
  assign out_fin = (out_cnt_q == out_num_q) ||
                   (out_hs && (out_cnt_q == (out_num_q - CNT_ONE)));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          // A zero-length layer skips the datapath entirely.
          state_d = cfg_zero ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // If outputs finished first, out_fin stays true and the layer ends
        // once the inputs catch up.
        if (in_fin && out_fin) begin
          state_d = ST_DONE;
        end else if (in_fin) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_fin) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    Busy             = 1'b0;
    Done             = 1'b0;
    bus.Conv_S_Valid = 1'b0;
    bus.S_Ready      = 1'b0;
    bus.M_Valid      = 1'b0;
    bus.Conv_M_Ready = 1'b0;

    Busy = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
           (state_q == ST_DRAIN);
    Done = (state_q == ST_DONE);

    bus.Conv_S_Valid = bus.S_Valid      && in_act;
    bus.S_Ready      = bus.Conv_S_Ready && in_act;
    bus.M_Valid      = bus.Conv_M_Valid && out_act;
    bus.Conv_M_Ready = bus.M_Ready      && out_act;
  end

  // --------------------------------------------------------------------------
  // Beat counters
  // --------------------------------------------------------------------------
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (state_q == ST_LOAD) begin
      in_cnt_d  = CNT_ZERO;
      out_cnt_d = CNT_ZERO;
    end else begin
      // Both sides may count in the same cycle.
      if (in_hs) begin
        in_cnt_d = in_cnt_q + CNT_ONE;
      end
      if (out_hs) begin
        out_cnt_d = out_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q  <= CNT_ZERO;
      out_cnt_q <= CNT_ZERO;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Layer configuration and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      in_num_q  <= CNT_ZERO;
      out_num_q <= CNT_ZERO;
      err_q     <= 1'b0;
    end else if (start_acc) begin
      // Configuration is captured only when a Start is honoured; Start while
      // busy or in DONE leaves everything untouched.
      sel_q     <= Cfg_Cin_Select;
      in_num_q  <= Cfg_In_Num;
      out_num_q <= Cfg_Out_Num;
      err_q     <= cfg_zero;
    end
  end

  // The mode select moves only in LOAD, one cycle before any beat can pass,
  // and then holds through DONE/IDLE until the next LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      en_q <= sel_q;
    end
  end

  assign EN_Cin_Select_REG = en_q;
  assign Err_Zero          = err_q;

endmodule : cin_convert_ctrl
`default_nettype wire

// File: tb/tb_cin_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cin_convert_ctrl
// Description : Directed self-checking bench for cin_convert_ctrl. Covers
//               bypass and convert layers, backpressure, zero-count config,
//               Start while busy / in DONE, and asynchronous reset mid-layer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cin_convert_ctrl;

  localparam int CNT_WIDTH = 20;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 Start;
  logic                 Cfg_Cin_Select;
  logic [CNT_WIDTH-1:0] Cfg_In_Num;
  logic [CNT_WIDTH-1:0] Cfg_Out_Num;
  logic                 EN_Cin_Select_REG;
  logic                 Busy;
  logic                 Done;
  logic                 Err_Zero;

  cin_convert_ctrl_if bus_if ();

  cin_convert_ctrl #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Start            (Start),
    .Cfg_Cin_Select   (Cfg_Cin_Select),
    .Cfg_In_Num       (Cfg_In_Num),
    .Cfg_Out_Num      (Cfg_Out_Num),
    .bus              (bus_if.slave),
    .EN_Cin_Select_REG(EN_Cin_Select_REG),
    .Busy             (Busy),
    .Done             (Done),
    .Err_Zero         (Err_Zero)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Environment: conversion datapath output is either a fixed level or a
  // 2-in / 1-out converter model driven from observed beat counts.
  // --------------------------------------------------------------------------
  logic conv_mode;
  logic cmv;
  int   in_hs;
  int   out_hs;
  int   done_cnt;
  int   viol_in;
  int   viol_out;
  int   drain_seen;
  int   in_tgt;
  int   out_tgt;
  logic mon_clr;

  assign bus_if.Conv_M_Valid = conv_mode ? ((in_hs / 2) > out_hs) : cmv;

  always @(posedge clk) begin
    if (mon_clr) begin
      in_hs      <= 0;
      out_hs     <= 0;
      done_cnt   <= 0;
      viol_in    <= 0;
      viol_out   <= 0;
      drain_seen <= 0;
    end else begin
      if (bus_if.S_Valid && bus_if.S_Ready) begin
        in_hs <= in_hs + 1;
        if (in_hs >= in_tgt) viol_in <= viol_in + 1;
      end
      if (bus_if.M_Valid && bus_if.M_Ready) begin
        out_hs <= out_hs + 1;
      end
      if (bus_if.M_Valid && (out_hs >= out_tgt)) viol_out <= viol_out + 1;
      if (Done) done_cnt <= done_cnt + 1;
      if (Busy && (in_hs == in_tgt) && !bus_if.S_Ready) drain_seen <= 1;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_mon(input int ti, input int to);
    in_tgt  = ti;
    out_tgt = to;
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  // Raises Start for one cycle; returns in cycle T+1.
  task automatic start_layer(input logic sel, input logic [CNT_WIDTH-1:0] ni,
                             input logic [CNT_WIDTH-1:0] no);
    Cfg_Cin_Select = sel;
    Cfg_In_Num     = ni;
    Cfg_Out_Num    = no;
    Start          = 1'b1;
    step();
    Start          = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while ((Done !== 1'b1) && (cyc < bound)) begin
      step();
      cyc++;
    end
    if (Done !== 1'b1) check("done_timeout", 32'(Done), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int cyc;

    rst_n               = 1'b0;
    Start               = 1'b0;
    Cfg_Cin_Select      = 1'b0;
    Cfg_In_Num          = '0;
    Cfg_Out_Num         = '0;
    bus_if.S_Valid      = 1'b1;
    bus_if.Conv_S_Ready = 1'b1;
    bus_if.M_Ready      = 1'b1;
    cmv                 = 1'b1;
    conv_mode           = 1'b0;
    mon_clr             = 1'b1;
    in_tgt              = 0;
    out_tgt             = 0;

    // Reset values
    step();
    step();
    check("rst_busy",   32'(Busy), 32'd0);
    check("rst_done",   32'(Done), 32'd0);
    check("rst_en",     32'(EN_Cin_Select_REG), 32'd0);
    check("rst_err",    32'(Err_Zero), 32'd0);
    check("rst_sready", 32'(bus_if.S_Ready), 32'd0);
    check("rst_mvalid", 32'(bus_if.M_Valid), 32'd0);
    rst_n = 1'b1;
    step();

    // ---- Bypass layer: In=Out=4, everything always ready ----
    clr_mon(4, 4);
    start_layer(1'b0, 20'd4, 20'd4);
    check("byp_load_busy",   32'(Busy), 32'd1);
    check("byp_load_sready", 32'(bus_if.S_Ready), 32'd0);
    step();
    check("byp_run_sready",  32'(bus_if.S_Ready), 32'd1);
    check("byp_run_mvalid",  32'(bus_if.M_Valid), 32'd1);
    check("byp_en",          32'(EN_Cin_Select_REG), 32'd0);
    wait_done(20, cyc);
    check("byp_done_lat",    32'(cyc), 32'd4);
    check("byp_done_busy",   32'(Busy), 32'd0);
    step();
    check("byp_done_pulse",  32'(Done), 32'd0);
    check("byp_in_cnt",      32'(in_hs), 32'd4);
    check("byp_out_cnt",     32'(out_hs), 32'd4);
    check("byp_done_cnt",    32'(done_cnt), 32'd1);

    // ---- Convert layer: In=8, Out=4, converter emits 1 per 2 ----
    conv_mode = 1'b1;
    clr_mon(8, 4);
    start_layer(1'b1, 20'd8, 20'd4);
    check("cnv_en_load", 32'(EN_Cin_Select_REG), 32'd0);
    step();
    check("cnv_en_run",  32'(EN_Cin_Select_REG), 32'd1);
    wait_done(40, cyc);
    check("cnv_done_lat", 32'(cyc), 32'd9);
    step();
    check("cnv_in_cnt",   32'(in_hs), 32'd8);
    check("cnv_out_cnt",  32'(out_hs), 32'd4);
    check("cnv_drain",    32'(drain_seen), 32'd1);
    check("cnv_viol_in",  32'(viol_in), 32'd0);
    check("cnv_done_cnt", 32'(done_cnt), 32'd1);
    check("cnv_en_hold",  32'(EN_Cin_Select_REG), 32'd1);
    conv_mode = 1'b0;

    // ---- Zero config: In=0 ----
    clr_mon(0, 0);
    start_layer(1'b0, 20'd0, 20'd4);
    check("zero_done",   32'(Done), 32'd1);
    check("zero_err",    32'(Err_Zero), 32'd1);
    check("zero_busy",   32'(Busy), 32'd0);
    check("zero_en",     32'(EN_Cin_Select_REG), 32'd1);
    check("zero_mvalid", 32'(bus_if.M_Valid), 32'd0);
    step();
    check("zero_pulse",  32'(Done), 32'd0);
    check("zero_sticky", 32'(Err_Zero), 32'd1);
    check("zero_beats",  32'(in_hs + out_hs), 32'd0);

    // ---- Backpressure: In=Out=16, M_Ready 1010, random S_Valid ----
    clr_mon(16, 16);
    start_layer(1'b0, 20'd16, 20'd16);
    check("bp_err_clr", 32'(Err_Zero), 32'd0);
    cyc = 0;
    while ((Done !== 1'b1) && (cyc < 400)) begin
      bus_if.S_Valid = 1'($urandom_range(0, 1));
      bus_if.M_Ready = ((cyc % 2) == 0);
      step();
      cyc++;
    end
    check("bp_done",     32'(Done), 32'd1);
    bus_if.S_Valid = 1'b1;
    bus_if.M_Ready = 1'b1;
    step();
    check("bp_in_cnt",   32'(in_hs), 32'd16);
    check("bp_out_cnt",  32'(out_hs), 32'd16);
    check("bp_viol_in",  32'(viol_in), 32'd0);
    check("bp_viol_out", 32'(viol_out), 32'd0);
    check("bp_done_cnt", 32'(done_cnt), 32'd1);
    check("bp_en",       32'(EN_Cin_Select_REG), 32'd0);

    // ---- Start abuse: Start during RUN and in DONE is ignored ----
    clr_mon(8, 8);
    start_layer(1'b1, 20'd8, 20'd8);
    step();
    step();
    start_layer(1'b0, 20'd2, 20'd2);
    check("abuse_en", 32'(EN_Cin_Select_REG), 32'd1);
    wait_done(30, cyc);
    check("abuse_done_lat", 32'(cyc), 32'd6);
    check("abuse_in_cnt",   32'(in_hs), 32'd8);
    check("abuse_out_cnt",  32'(out_hs), 32'd8);
    start_layer(1'b0, 20'd2, 20'd2);
    check("abuse_done_start", 32'(Busy), 32'd0);
    step();
    check("abuse_idle_busy",  32'(Busy), 32'd0);
    check("abuse_idle_en",    32'(EN_Cin_Select_REG), 32'd1);
    clr_mon(3, 3);
    start_layer(1'b0, 20'd3, 20'd3);
    check("new_start_busy", 32'(Busy), 32'd1);
    wait_done(30, cyc);
    step();
    check("new_in_cnt",  32'(in_hs), 32'd3);
    check("new_out_cnt", 32'(out_hs), 32'd3);
    check("new_en",      32'(EN_Cin_Select_REG), 32'd0);

    // ---- Reset mid-RUN after 3 of 8 beats ----
    clr_mon(8, 8);
    start_layer(1'b1, 20'd8, 20'd8);
    step();
    step();
    step();
    step();
    check("mid_in_cnt", 32'(in_hs), 32'd3);
    check("mid_en",     32'(EN_Cin_Select_REG), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(Busy), 32'd0);
    check("arst_en",     32'(EN_Cin_Select_REG), 32'd0);
    check("arst_done",   32'(Done), 32'd0);
    check("arst_sready", 32'(bus_if.S_Ready), 32'd0);
    check("arst_mvalid", 32'(bus_if.M_Valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("arst_no_done", 32'(done_cnt), 32'd0);
    clr_mon(2, 2);
    start_layer(1'b0, 20'd2, 20'd2);
    wait_done(20, cyc);
    check("post_done_lat", 32'(cyc), 32'd3);
    step();
    check("post_in_cnt",   32'(in_hs), 32'd2);
    check("post_out_cnt",  32'(out_hs), 32'd2);
    check("post_done_cnt", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_cin_convert_ctrl
`default_nettype wire
